// File: rtl/rand_arbiter_if.sv
// rand_arbiter_if: requester and generator signals shared by the arbiter and its environment
interface rand_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] seed_in;
    logic                    gen_done;
    logic [DATA_W-1:0]       gen_value;
    logic                    gen_start;
    logic [DATA_W-1:0]       gen_seed;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       rnd_out;
    logic                    err;
    logic                    busy;
    modport master (
        output req, seed_in, gen_done, gen_value,
        input  gen_start, gen_seed, ack, rnd_out, err, busy
    );
    modport slave (
        input  req, seed_in, gen_done, gen_value,
        output gen_start, gen_seed, ack, rnd_out, err, busy
    );
endinterface

// File: rtl/rand_arbiter.sv
// rand_arbiter: round-robin sharing of one random generator among N_REQ requesters,
// with a watchdog that aborts a transaction whose generator never reports done
module rand_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input logic          clk,
    input logic          rst,
    rand_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, WAIT = 2'd2, DELIVER = 2'd3;
    logic [1:0]       state;
    logic [IW-1:0]    rr_ptr, grant, win;
    logic [CW-1:0]    wait_cnt;
    logic [N_REQ-1:0] grant_oh;
    // scan downward so the lowest offset from rr_ptr wins
    always_comb begin
        win = rr_ptr;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (bus.req[(int'(rr_ptr) + k) % N_REQ]) win = IW'((int'(rr_ptr) + k) % N_REQ);
    end
    assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant;
    // wait_cnt counts cycles since GRANT, so the abort lands TIMEOUT cycles after GRANT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant         <= '0;
            wait_cnt      <= '0;
            bus.gen_start <= 1'b0;
            bus.gen_seed  <= '0;
            bus.ack       <= '0;
            bus.rnd_out   <= '0;
            bus.err       <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.gen_start <= 1'b0;
            bus.ack       <= '0;
            bus.rnd_out   <= '0;
            bus.err       <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (|bus.req) begin
                        grant         <= win;
                        bus.gen_seed  <= bus.seed_in[int'(win)*DATA_W +: DATA_W];
                        bus.gen_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (bus.gen_done) begin
                        bus.rnd_out <= bus.gen_value;
                        bus.ack     <= grant_oh;
                        state       <= DELIVER;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        bus.err <= 1'b1;
                        bus.ack <= grant_oh;
                        state   <= DELIVER;
                    end
                end
                default: begin
                    rr_ptr   <= (grant == IW'(N_REQ - 1)) ? '0 : grant + IW'(1);
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rand_arbiter.sv
// tb_rand_arbiter: directed cycle-by-cycle checks of arbitration order, latency, timeout and reset
module tb_rand_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] seeds [4] = '{8'h11, 8'h22, 8'h5A, 8'h44};
    always #5 clk = ~clk;
    rand_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();
    rand_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // entered at the negedge of an IDLE cycle with req already driven; returns at the next IDLE negedge
    task automatic transact(input string tag, input int idx, input int dly, input logic [7:0] val,
                            input logic [3:0] req_wait);
        logic [3:0] exp_ack;
        exp_ack = 4'(1 << idx);
        @(negedge clk);
        chk({tag, ".start"}, bus.gen_start, 1);
        chk({tag, ".seed"}, bus.gen_seed, seeds[idx]);
        chk({tag, ".busy"}, bus.busy, 1);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (i == 0) bus.req = req_wait;
            chk({tag, ".wait_ack"}, bus.ack, 0);
            chk({tag, ".wait_start"}, bus.gen_start, 0);
            chk({tag, ".wait_seed"}, bus.gen_seed, seeds[idx]);
        end
        bus.gen_done  = 1'b1;
        bus.gen_value = val;
        @(negedge clk);
        bus.gen_done  = 1'b0;
        bus.gen_value = 8'h00;
        chk({tag, ".ack"}, bus.ack, exp_ack);
        chk({tag, ".rnd"}, bus.rnd_out, val);
        chk({tag, ".err"}, bus.err, 0);
        @(negedge clk);
        chk({tag, ".ack_clr"}, bus.ack, 0);
        chk({tag, ".rnd_clr"}, bus.rnd_out, 0);
        chk({tag, ".idle"}, bus.busy, 0);
    endtask

    initial begin
        bus.req       = 4'b0000;
        bus.seed_in   = {seeds[3], seeds[2], seeds[1], seeds[0]};
        bus.gen_done  = 1'b0;
        bus.gen_value = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst.busy", bus.busy, 0);
        chk("rst.start", bus.gen_start, 0);
        chk("rst.seed", bus.gen_seed, 0);
        chk("rst.ack", bus.ack, 0);
        rst = 1'b0;
        // reset while waiting on the generator
        bus.req = 4'b0100;
        @(negedge clk);
        chk("midrst.start", bus.gen_start, 1);
        repeat (2) @(negedge clk);
        chk("midrst.busy_pre", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst.busy", bus.busy, 0);
        chk("midrst.seed", bus.gen_seed, 0);
        chk("midrst.ack", bus.ack, 0);
        chk("midrst.err", bus.err, 0);
        bus.req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst.no_ack", bus.ack, 0);
            chk("midrst.idle", bus.busy, 0);
        end
        // round robin from pointer 0 with all requesters active
        bus.req = 4'b1111;
        transact("rr0", 0, 3, 8'hA1, 4'b1111);
        transact("rr1", 1, 3, 8'hA2, 4'b1111);
        transact("rr2", 2, 3, 8'hA3, 4'b1111);
        transact("rr3", 3, 3, 8'hA4, 4'b1111);
        transact("rr4", 0, 3, 8'hA5, 4'b0000);
        // single request, done five cycles after start
        bus.req = 4'b0100;
        transact("single", 2, 5, 8'hC3, 4'b0000);
        // pointer now 3: requester 0 wins by wrap-around, then requester 1
        bus.req = 4'b0011;
        transact("wrap0", 0, 2, 8'h3C, 4'b0011);
        transact("wrap1", 1, 2, 8'h96, 4'b0000);
        // timeout: generator never answers
        bus.req = 4'b0001;
        @(negedge clk);
        chk("to.start", bus.gen_start, 1);
        bus.req = 4'b0000;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("to.wait_ack", bus.ack, 0);
        end
        @(negedge clk);
        chk("to.ack", bus.ack, 4'b0001);
        chk("to.err", bus.err, 1);
        chk("to.rnd", bus.rnd_out, 0);
        chk("to.busy", bus.busy, 1);
        @(negedge clk);
        chk("to.idle", bus.busy, 0);
        chk("to.err_clr", bus.err, 0);
        // requester 1 withdraws during WAIT but is still served
        bus.req = 4'b0010;
        transact("withdraw", 1, 4, 8'h7E, 4'b0000);
        // stray done while idle
        bus.gen_done  = 1'b1;
        bus.gen_value = 8'hEE;
        @(negedge clk);
        bus.gen_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stray.ack", bus.ack, 0);
            chk("stray.rnd", bus.rnd_out, 0);
            chk("stray.busy", bus.busy, 0);
            chk("stray.start", bus.gen_start, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
